// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - mode encoding, default timing constants and mode step function
package clock_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2
    } mode_t;

    localparam int DB_CYC_DEF  = 4;
    localparam int RPT_DLY_DEF = 8;
    localparam int RPT_PER_DEF = 4;

    // Encoding 3 is unreachable but falls back to RUN whether or not a press is seen.
    function automatic mode_t step_mode(mode_t m, logic press);
        mode_t r;
        case (m)
            RUN:       r = press ? SET_TIME  : RUN;
            SET_TIME:  r = press ? SET_ALARM : SET_TIME;
            SET_ALARM: r = press ? RUN       : SET_ALARM;
            default:   r = RUN;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/debounce.sv
// rtl/debounce.sv - 2-flop synchronizer, stable-sample debouncer and rise pulse
module debounce #(
    parameter int DB_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_END = CW'(DB_CYC - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // cnt holds how many consecutive samples have disagreed with level so far.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt >= CNT_END) begin
                level <= s2;
                rise  <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_ctrl.sv
// rtl/btn_ctrl.sv - button front end: mode FSM, advance repeat engines, alarm toggle
module btn_ctrl
    import clock_pkg::*;
#(
    parameter int DB_CYC  = DB_CYC_DEF,
    parameter int RPT_DLY = RPT_DLY_DEF,
    parameter int RPT_PER = RPT_PER_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_min,
    input  logic       btn_hrs,
    input  logic       btn_alarm,
    output logic       Timeset,
    output logic       Alarmset,
    output logic       Minadv,
    output logic       Hrsadv,
    output logic       Alarmon,
    output logic [1:0] mode
);

    localparam int RMAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DLY_END = RW'(RPT_DLY - 1);
    localparam logic [RW-1:0] PER_END = RW'(RPT_PER - 1);
    localparam logic [RW-1:0] CNT_SAT = RW'(RMAX);

    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] rise;
    logic       unused_lvl;

    assign raw = {btn_alarm, btn_hrs, btn_min, btn_mode};

    for (genvar g = 0; g < 4; g++) begin : g_db
        debounce #(.DB_CYC(DB_CYC)) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw[g]),
            .level (lvl[g]),
            .rise  (rise[g])
        );
    end

    // Mode and alarm buttons act only on their press pulse.
    assign unused_lvl = lvl[0] ^ lvl[3];

    mode_t          state;
    mode_t          nxt;
    logic [1:0]     act;
    logic [1:0]     rep;
    logic [1:0]     strb;
    logic [RW-1:0]  rcnt [2];

    assign nxt = step_mode(state, rise[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            Timeset  <= 1'b0;
            Alarmset <= 1'b0;
            Alarmon  <= 1'b0;
            act      <= '0;
            rep      <= '0;
            strb     <= '0;
            for (int i = 0; i < 2; i++) rcnt[i] <= '0;
        end else begin
            state    <= nxt;
            Timeset  <= (nxt == SET_TIME);
            Alarmset <= (nxt == SET_ALARM);
            if (rise[3]) Alarmon <= ~Alarmon;

            // A mode change disarms a held advance button until it is released and pressed again.
            for (int i = 0; i < 2; i++) begin
                strb[i] <= 1'b0;
                if (nxt != state || !lvl[i+1]) begin
                    act[i]  <= 1'b0;
                    rep[i]  <= 1'b0;
                    rcnt[i] <= '0;
                end else if (rise[i+1] && (state == SET_TIME || state == SET_ALARM)) begin
                    act[i]  <= 1'b1;
                    rep[i]  <= 1'b0;
                    rcnt[i] <= '0;
                    strb[i] <= 1'b1;
                end else if (act[i]) begin
                    if (rcnt[i] == (rep[i] ? PER_END : DLY_END)) begin
                        strb[i] <= 1'b1;
                        rep[i]  <= 1'b1;
                        rcnt[i] <= '0;
                    end else if (rcnt[i] != CNT_SAT) begin
                        rcnt[i] <= rcnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign Minadv = strb[0];
    assign Hrsadv = strb[1];
    assign mode   = state;

endmodule

// File: tb/tb_btn_ctrl.sv
// tb/tb_btn_ctrl.sv - directed and randomized bench for btn_ctrl against a behavioural model
module tb_btn_ctrl;

    localparam int DB  = 4;
    localparam int DLY = 8;
    localparam int PER = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode, btn_min, btn_hrs, btn_alarm;
    logic       Timeset, Alarmset, Minadv, Hrsadv, Alarmon;
    logic [1:0] mode;

    always #5 clk = ~clk;

    btn_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_min   (btn_min),
        .btn_hrs   (btn_hrs),
        .btn_alarm (btn_alarm),
        .Timeset   (Timeset),
        .Alarmset  (Alarmset),
        .Minadv    (Minadv),
        .Hrsadv    (Hrsadv),
        .Alarmon   (Alarmon),
        .mode      (mode)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Behavioural model: window-of-samples debounce, press edges, mode counter mod 3,
    // repeat strobes as arithmetic on the distance from the first strobe.
    int          ecnt = 0;
    logic [3:0]  m_s1 = '0, m_s2 = '0, m_lvl = '0, m_rise = '0;
    logic [DB-1:0] m_win [4];
    int          m_mode = 0;
    logic        m_al = 1'b0;
    logic [1:0]  m_eng = '0, m_strb = '0;
    int          m_t0 [2];
    logic [3:0]  m_raw;
    int          m_d;

    initial for (int i = 0; i < 4; i++) m_win[i] = '0;

    always @(posedge clk) begin
        ecnt++;
        m_raw = {btn_alarm, btn_hrs, btn_min, btn_mode};
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0;
            m_mode = 0; m_al = 1'b0; m_eng = '0; m_strb = '0;
            for (int i = 0; i < 4; i++) m_win[i] = '0;
        end else begin
            m_strb = '0;
            for (int b = 0; b < 2; b++) begin
                if (m_rise[0]) m_eng[b] = 1'b0;
                else if (m_rise[b+1] && m_mode != 0) begin
                    m_eng[b] = 1'b1;
                    m_t0[b]  = ecnt;
                end else if (!m_lvl[b+1]) m_eng[b] = 1'b0;
                if (m_eng[b]) begin
                    m_d = ecnt - m_t0[b];
                    m_strb[b] = (m_d == 0) || (m_d >= DLY && (m_d - DLY) % PER == 0);
                end
            end
            if (m_rise[0]) m_mode = (m_mode + 1) % 3;
            if (m_rise[3]) m_al = ~m_al;
            for (int i = 0; i < 4; i++) begin
                m_win[i]  = {m_win[i][DB-2:0], m_s2[i]};
                m_rise[i] = 1'b0;
                if (m_win[i] == '1 && !m_lvl[i]) begin
                    m_lvl[i]  = 1'b1;
                    m_rise[i] = 1'b1;
                end else if (m_win[i] == '0 && m_lvl[i]) begin
                    m_lvl[i] = 1'b0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = m_raw[i];
            end
        end
    end

    logic cmp_on = 1'b0;

    always @(negedge clk) begin
        if (cmp_on)
            chk("outputs_vs_model",
                int'({Timeset, Alarmset, Minadv, Hrsadv, Alarmon, mode}),
                int'({m_mode == 1, m_mode == 2, m_strb[0], m_strb[1], m_al, 2'(m_mode)}));
    end

    int n_min = 0, n_hrs = 0;
    int min_t [$];

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            if (Minadv) begin
                n_min++;
                min_t.push_back(ecnt);
            end
            if (Hrsadv) n_hrs++;
        end
    endtask

    task automatic press(int which);
        case (which)
            0: btn_mode  = 1'b1;
            1: btn_min   = 1'b1;
            2: btn_hrs   = 1'b1;
            default: btn_alarm = 1'b1;
        endcase
        step(8);
        btn_mode = 1'b0; btn_min = 1'b0; btn_hrs = 1'b0; btn_alarm = 1'b0;
        step(10);
    endtask

    int k, t;
    int cd [4];
    logic [3:0] val;

    initial begin
        rst = 1'b1;
        btn_mode = 1'b0; btn_min = 1'b0; btn_hrs = 1'b0; btn_alarm = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_mode", int'(mode), 0);
        chk("reset_timeset", int'(Timeset), 0);
        chk("reset_alarmset", int'(Alarmset), 0);
        chk("reset_minadv", int'(Minadv), 0);
        chk("reset_hrsadv", int'(Hrsadv), 0);
        chk("reset_alarmon", int'(Alarmon), 0);
        cmp_on = 1'b1;
        rst = 1'b0;
        step(3);

        for (int i = 0; i < 10; i++) begin
            btn_mode = (i % 2 == 0);
            step(2);
        end
        chk("bounce_rejected", int'(mode), 0);
        btn_mode = 1'b1;
        k = ecnt + 1;
        t = -1;
        for (int i = 0; i < 20 && t < 0; i++) begin
            step(1);
            if (Timeset) t = ecnt;
        end
        chk("bounce_timeset_latency", t - k, 6);
        step(10);
        btn_mode = 1'b0;
        step(12);
        chk("bounce_single_step", int'(mode), 1);

        n_min = 0; n_hrs = 0; min_t.delete();
        btn_min = 1'b1;
        k = ecnt + 1;
        step(30);
        btn_min = 1'b0;
        step(15);
        chk("repeat_count", n_min, 7);
        chk("repeat_first", min_t.size() > 0 ? min_t[0] - k : -1, 6);
        chk("repeat_dly", min_t.size() > 1 ? min_t[1] - min_t[0] : -1, DLY);
        chk("repeat_per", min_t.size() > 2 ? min_t[2] - min_t[1] : -1, PER);
        chk("repeat_last", min_t.size() > 6 ? min_t[6] - k : -1, 34);
        chk("repeat_hrs_quiet", n_hrs, 0);

        press(0);
        press(0);
        chk("back_to_run", int'(mode), 0);
        n_hrs = 0;
        press(2);
        chk("run_ignores_hrs", n_hrs, 0);
        press(3);
        chk("alarm_on", int'(Alarmon), 1);
        press(3);
        chk("alarm_off", int'(Alarmon), 0);

        press(0);
        chk("enter_set_time", int'(mode), 1);
        n_hrs = 0;
        btn_hrs = 1'b1;
        step(15);
        chk("held_hrs_strobes", n_hrs, 2);
        btn_mode = 1'b1;
        step(8);
        btn_mode = 1'b0;
        n_hrs = 0;
        step(30);
        chk("held_mode_change", int'(mode), 2);
        chk("held_hrs_suppressed", n_hrs, 0);
        btn_hrs = 1'b0;
        step(10);
        press(2);
        chk("hrs_repress", n_hrs, 1);

        press(0);
        chk("cycle_run", int'(mode), 0);
        press(0);
        chk("cycle_p1", int'(mode), 1);
        press(0);
        chk("cycle_p2", int'(mode), 2);
        press(0);
        chk("cycle_p3", int'(mode), 0);

        press(0);
        n_min = 0;
        btn_mode = 1'b1;
        btn_min  = 1'b1;
        step(8);
        btn_mode = 1'b0;
        btn_min  = 1'b0;
        step(10);
        chk("collision_mode", int'(mode), 2);
        chk("collision_no_minadv", n_min, 0);

        for (int i = 0; i < 4; i++) cd[i] = 0;
        val = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (cd[i] == 0) begin
                    val[i] = 1'($urandom_range(0, 1));
                    cd[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                         : int'($urandom_range(6, 40));
                end else begin
                    cd[i]--;
                end
            end
            {btn_alarm, btn_hrs, btn_min, btn_mode} = val;
            rst = ($urandom_range(0, 599) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
